cone_match_pipe: RTL

//  Parametrised, pipelined successor to the fixed AES decode/AOI timing cones.

---
 rtl/cone_match_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/cone_match_pipe.sv
// Per-lane care/value match with AOI bypass combine, behind a stall-together valid/ready pipeline.
// Optional per-lane saturating hit counters when CONE_MATCH_STATS_EN is defined.
module cone_match_pipe #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 4,
    parameter int STAGES   = 2,
    localparam int MW      = WIDTH - 2,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [MW-1:0]             cfg_care,
    input  logic [MW-1:0]             cfg_value,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       out_y,
    output logic [CHANNELS-1:0]       out_hit
`ifdef CONE_MATCH_STATS_EN
    ,
    output logic [CHANNELS*16-1:0]    hit_cnt
`endif
);

    logic                adv;
    logic                accept;
    logic [CHANNELS-1:0] hit_next;
    logic [CHANNELS-1:0] y_next;

    logic [MW-1:0]       care_reg  [CHANNELS];
    logic [MW-1:0]       value_reg [CHANNELS];

    logic                valid_reg [STAGES];
    logic [CHANNELS-1:0] hit_reg   [STAGES];
    logic [CHANNELS-1:0] y_reg     [STAGES];

    // Whole pipe stalls together: it only moves when the output slot is free or draining.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & adv;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic [WIDTH-1:0] lane_d;
            assign lane_d       = in_data[gi*WIDTH +: WIDTH];
            assign hit_next[gi] = &(~(lane_d[MW-1:0] ^ value_reg[gi]) | ~care_reg[gi]);
            assign y_next[gi]   = ~((lane_d[WIDTH-1] & lane_d[WIDTH-2]) | hit_next[gi]);
        end
    endgenerate

    // Mask write lands at the edge, so a beat accepted in the same cycle still sees the old mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                care_reg[c]  <= '0;
                value_reg[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (cfg_we && (cfg_ch == CH_W'(c))) begin
                    care_reg[c]  <= cfg_care;
                    value_reg[c] <= cfg_value;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_reg[s] <= 1'b0;
                hit_reg[s]   <= '0;
                y_reg[s]     <= '0;
            end
        end else if (adv) begin
            valid_reg[0] <= accept;
            if (accept) begin
                hit_reg[0] <= hit_next;
                y_reg[0]   <= y_next;
            end
            for (int s = 1; s < STAGES; s++) begin
                valid_reg[s] <= valid_reg[s-1];
                hit_reg[s]   <= hit_reg[s-1];
                y_reg[s]     <= y_reg[s-1];
            end
        end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign out_hit   = hit_reg[STAGES-1];
    assign out_y     = y_reg[STAGES-1];

`ifdef CONE_MATCH_STATS_EN
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_stats
            logic [15:0] cnt_reg;
            // A lane clear on cfg_we takes priority over a retiring hit in the same cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (cfg_we && (cfg_ch == CH_W'(gi))) begin
                    cnt_reg <= '0;
                end else if (out_valid && out_ready && out_hit[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
            assign hit_cnt[gi*16 +: 16] = cnt_reg;
        end
    endgenerate
`endif

endmodule
